// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared state type and constants for the RAM playback controller
package playback_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int ADDR_W    = 10;
   localparam int WORD_W    = 32;
   localparam int BEAT_W    = 16;
   localparam int RAM_DEPTH = 2 ** ADDR_W;

endpackage

// File: rtl/ram_playback_ctrl_if.sv
// rtl/ram_playback_ctrl_if.sv - playback stream (data_out/valid/ready, ready latency 0)
interface ram_playback_ctrl_if;
   import playback_pkg::*;

   logic [BEAT_W-1:0] data_out;
   logic              valid;
   logic              ready;

   modport master (output data_out, output valid, input ready);
   modport slave  (input data_out, input valid, output ready);

endinterface

// File: rtl/playback_fifo.sv
// rtl/playback_fifo.sv - synchronous output FIFO; head is read straight from storage
module playback_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk_hifreq,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_hifreq or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
      end
   end

endmodule

// File: rtl/ram_playback_ctrl.sv
// rtl/ram_playback_ctrl.sv - RAM playback sequencer with host write arbitration; PLAYBACK_SPLIT_EN streams both word halves
module ram_playback_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic                             clk_hifreq,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             stop,
   input  logic [ADDR_W-1:0]                cfg_base,
   input  logic [ADDR_W:0]                  cfg_len,
   input  logic                             cfg_loop,
   input  logic                             wr_req,
   input  logic [ADDR_W-1:0]                wr_addr,
   input  logic [playback_pkg::WORD_W-1:0]  wr_data,
   output logic                             wr_ack,
   output logic [ADDR_W-1:0]                ram_address,
   output logic [playback_pkg::WORD_W-1:0]  ram_data,
   output logic                             ram_wren,
   input  logic [playback_pkg::WORD_W-1:0]  ram_q,
   ram_playback_ctrl_if.master              st,
   output logic                             busy,
   output logic                             done
);
   import playback_pkg::*;

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int WAIT_W = $clog2(STARVE_MAX + 1);
`ifdef PLAYBACK_SPLIT_EN
   localparam int FIFO_W = WORD_W;
`else
   localparam int FIFO_W = BEAT_W;
`endif

   state_t             state;
   logic [ADDR_W-1:0]  base;
   logic [ADDR_W:0]    len;
   logic [ADDR_W:0]    offset;
   logic               loop_en;
   logic [RD_LAT-1:0]  pipe;
   logic [RD_LAT-1:0]  pipe_next;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]   in_flight;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   count_next;
   logic [FIFO_W-1:0]  fifo_din;
   logic [FIFO_W-1:0]  fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               credit_ok, starve, issue, grant, last_word, drained;
   logic               push, pop;
   logic               unused_bits;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CNT_W'(pipe[i]);
   end

   // Credit counts words already in flight so every returning word has a slot.
   assign credit_ok = (fifo_count + in_flight) < CNT_W'(FIFO_DEPTH);
   assign starve    = wr_req && (wait_cnt >= WAIT_W'(STARVE_MAX));
   assign issue     = (state == RUN) && credit_ok && !starve;
   assign grant     = rst_n && wr_req && !issue;
   assign last_word = (offset == len - 1'b1);

   assign ram_address = issue ? base + offset[ADDR_W-1:0] : (grant ? wr_addr : '0);
   assign ram_wren    = grant;
   assign wr_ack      = grant;
   assign ram_data    = grant ? wr_data : '0;

   assign push       = pipe[RD_LAT-1];
   assign pipe_next  = (pipe << 1) | RD_LAT'(issue);
   assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign drained    = (pipe_next == '0) && (count_next == '0);
   assign st.valid   = !fifo_empty;

`ifdef PLAYBACK_SPLIT_EN
   logic half;

   always_ff @(posedge clk_hifreq or negedge rst_n) begin
      if (!rst_n)                   half <= 1'b0;
      else if (st.valid && st.ready) half <= !half;
   end

   // A word leaves the FIFO only once its high beat has transferred.
   assign pop         = st.valid && st.ready && half;
   assign fifo_din    = ram_q;
   assign st.data_out = half ? fifo_head[WORD_W-1:BEAT_W] : fifo_head[BEAT_W-1:0];
   assign unused_bits = fifo_full;
`else
   assign pop         = st.valid && st.ready;
   assign fifo_din    = ram_q[BEAT_W-1:0];
   assign st.data_out = fifo_head;
   assign unused_bits = ^{ram_q[WORD_W-1:BEAT_W], fifo_full};
`endif

   playback_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_hifreq (clk_hifreq),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (fifo_din),
      .pop        (pop),
      .head       (fifo_head),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   always_ff @(posedge clk_hifreq or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         base     <= '0;
         len      <= '0;
         offset   <= '0;
         loop_en  <= 1'b0;
         pipe     <= '0;
         wait_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         pipe <= pipe_next;
         done <= 1'b0;
         if (grant || !wr_req)            wait_cnt <= '0;
         else if (state == RUN)           wait_cnt <= wait_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (start && cfg_len != '0) begin
                  base    <= cfg_base;
                  len     <= cfg_len;
                  loop_en <= cfg_loop;
                  offset  <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (issue) offset <= last_word ? '0 : offset + 1'b1;
               if (stop || (issue && last_word && !loop_en)) state <= DRAIN;
            end
            DRAIN: begin
               if (drained) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_playback_ctrl.sv
// tb/tb_ram_playback_ctrl.sv - directed self-checking bench for ram_playback_ctrl
module tb_ram_playback_ctrl;

   localparam int STARVE_MAX = 8;

   logic        clk_hifreq = 1'b0;
   logic        rst_n      = 1'b0;
   logic        start      = 1'b0;
   logic        stop       = 1'b0;
   logic        cfg_loop   = 1'b0;
   logic        wr_req     = 1'b0;
   logic [9:0]  cfg_base   = '0;
   logic [9:0]  wr_addr    = '0;
   logic [10:0] cfg_len    = '0;
   logic [31:0] wr_data    = '0;
   logic [31:0] ram_q;
   logic [31:0] ram_data;
   logic [9:0]  ram_address;
   logic        wr_ack, ram_wren, busy, done;

   ram_playback_ctrl_if st_if ();

   ram_playback_ctrl dut (
      .clk_hifreq  (clk_hifreq),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .cfg_base    (cfg_base),
      .cfg_len     (cfg_len),
      .cfg_loop    (cfg_loop),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .st          (st_if.master),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk_hifreq = ~clk_hifreq;

   // RAM model: word i holds 0x1000+i until written; registered address, 1-cycle read
   logic [31:0] ram [1024];
   bit          written [1024];

   always @(posedge clk_hifreq) begin
      if (ram_wren) begin
         ram[ram_address]     <= ram_data;
         written[ram_address] <= 1'b1;
      end
      ram_q <= written[ram_address] ? ram[ram_address] : 32'h1000 + 32'(ram_address);
   end

   int          checks = 0;
   int          failures = 0;
   int          cyc, done_cnt, done_cyc, ack_cnt, ack_cyc, stall_glitch, ovf;
   logic [9:0]  ack_addr;
   logic [31:0] ack_data;
   logic        held;
   logic [15:0] held_data;
   logic [15:0] got [$];
   int          beat_cyc [$];

   task automatic clear_mon();
      got.delete();
      beat_cyc.delete();
      cyc = 0; done_cnt = 0; done_cyc = -1; ack_cnt = 0; ack_cyc = -1;
      stall_glitch = 0; ovf = 0; held = 1'b0; held_data = '0;
   endtask

   task automatic tick();
      #1;
      if (st_if.valid && st_if.ready) begin
         got.push_back(st_if.data_out);
         beat_cyc.push_back(cyc);
      end
      if (held && st_if.data_out !== held_data) stall_glitch++;
      held      = st_if.valid && !st_if.ready;
      held_data = st_if.data_out;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (wr_ack) begin ack_cnt++; ack_cyc = cyc; ack_addr = ram_address; ack_data = ram_data; end
      if (dut.push && dut.fifo_full) ovf++;
      @(posedge clk_hifreq);
      #1;
      cyc++;
   endtask

   task automatic start_pass(input logic [9:0] b, input logic [10:0] l, input logic lp);
      cfg_base = b; cfg_len = l; cfg_loop = lp;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && done_cnt == 0; k++) tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      st_if.ready = 1'b0;
      repeat (3) @(posedge clk_hifreq);
      #1;
      checks++;
      if ({st_if.valid, busy, done, wr_ack, ram_wren} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000", {st_if.valid, busy, done, wr_ack, ram_wren});
      end
      checks++;
      if (ram_address !== 10'd0 || ram_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_ram_bus got=%h/%h exp=000/00000000", ram_address, ram_data);
      end
      checks++;
      if (st_if.data_out !== 16'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0000", st_if.data_out);
      end
      rst_n = 1'b1;
      clear_mon();
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || done_cnt != 0) begin
         failures++;
         $display("FAIL reset_idle got=busy%b/done%0d exp=busy0/done0", busy, done_cnt);
      end
   endtask

   task automatic test_basic();
      logic [15:0] act;
      clear_mon();
      st_if.ready = 1'b1;
      start_pass(10'd5, 11'd4, 1'b0);
      wait_done(40);
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL basic_count got=%0d exp=4", got.size());
      end
      for (int i = 0; i < 4; i++) begin
         act = (i < got.size()) ? got[i] : 16'hxxxx;
         checks++;
         if (act !== 16'h1005 + 16'(i)) begin
            failures++;
            $display("FAIL basic_beat%0d got=%h exp=%h", i, act, 16'h1005 + 16'(i));
         end
      end
      checks++;
      if (beat_cyc.size() < 4 || beat_cyc[0] != 3 || beat_cyc[3] != 6) begin
         failures++;
         $display("FAIL basic_timing got=%0d..%0d exp=3..6",
                  beat_cyc.size() > 0 ? beat_cyc[0] : -1, beat_cyc.size() > 3 ? beat_cyc[3] : -1);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != 7) begin
         failures++;
         $display("FAIL basic_done got=cnt%0d/cyc%0d exp=cnt1/cyc7", done_cnt, done_cyc);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_w [4];
      logic [15:0] act;
      exp_w = '{16'h13FE, 16'h13FF, 16'h1000, 16'h1001};
      clear_mon();
      st_if.ready = 1'b1;
      start_pass(10'd1022, 11'd4, 1'b0);
      wait_done(40);
      for (int i = 0; i < 4; i++) begin
         act = (i < got.size()) ? got[i] : 16'hxxxx;
         checks++;
         if (act !== exp_w[i]) begin
            failures++;
            $display("FAIL wrap_beat%0d got=%h exp=%h", i, act, exp_w[i]);
         end
      end
      checks++;
      if (got.size() != 4 || done_cnt != 1) begin
         failures++;
         $display("FAIL wrap_end got=beats%0d/done%0d exp=beats4/done1", got.size(), done_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] pat;
      logic [15:0] act;
      pat = 32'b1001_1100_0101_1001_0011_0110_1000_1101;
      clear_mon();
      st_if.ready = 1'b1;
      start_pass(10'd100, 11'd16, 1'b0);
      for (int k = 0; k < 200 && done_cnt == 0; k++) begin
         st_if.ready = pat[k % 32];
         tick();
      end
      st_if.ready = 1'b1;
      tick();
      checks++;
      if (got.size() != 16) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=16", got.size());
      end
      for (int i = 0; i < 16; i++) begin
         act = (i < got.size()) ? got[i] : 16'hxxxx;
         checks++;
         if (act !== 16'h1064 + 16'(i)) begin
            failures++;
            $display("FAIL bp_beat%0d got=%h exp=%h", i, act, 16'h1064 + 16'(i));
         end
      end
      checks++;
      if (stall_glitch != 0) begin
         failures++;
         $display("FAIL bp_stable got=%0d exp=0", stall_glitch);
      end
      checks++;
      if (ovf != 0) begin
         failures++;
         $display("FAIL bp_overflow got=%0d exp=0", ovf);
      end
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL bp_done got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_loop_stop();
      logic [15:0] act;
      clear_mon();
      st_if.ready = 1'b1;
      start_pass(10'd200, 11'd3, 1'b1);
      while (cyc < 10) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(40);
      checks++;
      if (got.size() != 10) begin
         failures++;
         $display("FAIL loop_count got=%0d exp=10", got.size());
      end
      for (int i = 0; i < 10; i++) begin
         act = (i < got.size()) ? got[i] : 16'hxxxx;
         checks++;
         if (act !== 16'h10C8 + 16'(i % 3)) begin
            failures++;
            $display("FAIL loop_beat%0d got=%h exp=%h", i, act, 16'h10C8 + 16'(i % 3));
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != 13) begin
         failures++;
         $display("FAIL loop_done got=cnt%0d/cyc%0d exp=cnt1/cyc13", done_cnt, done_cyc);
      end
   endtask

   task automatic test_write_contention();
      logic [15:0] act;
      int          req_cyc;
      clear_mon();
      st_if.ready = 1'b1;
      wr_addr = 10'd600; wr_data = 32'h5A5A_0600; wr_req = 1'b1;
      #1;
      checks++;
      if (wr_ack !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 10'd600 || ram_data !== 32'h5A5A_0600) begin
         failures++;
         $display("FAIL idle_write got=%b%b/%h/%h exp=11/258/5a5a0600", wr_ack, ram_wren, ram_address, ram_data);
      end
      tick();
      wr_req = 1'b0;
      tick();

      clear_mon();
      start_pass(10'd300, 11'd40, 1'b0);
      while (cyc < 5) tick();
      wr_addr = 10'd500; wr_data = 32'h0000_BEEF; wr_req = 1'b1;
      req_cyc = cyc;
      while (ack_cnt == 0 && cyc < 60) tick();
      wr_req = 1'b0;
      wait_done(100);
      checks++;
      if (ack_cnt != 1 || ack_cyc - req_cyc > STARVE_MAX) begin
         failures++;
         $display("FAIL starve_ack got=cnt%0d/wait%0d exp=cnt1/wait<=%0d", ack_cnt, ack_cyc - req_cyc, STARVE_MAX);
      end
      checks++;
      if (ack_addr !== 10'd500 || ack_data !== 32'h0000_BEEF) begin
         failures++;
         $display("FAIL starve_bus got=%h/%h exp=1f4/0000beef", ack_addr, ack_data);
      end
      checks++;
      if (got.size() != 40) begin
         failures++;
         $display("FAIL starve_count got=%0d exp=40", got.size());
      end
      for (int i = 0; i < 40; i++) begin
         act = (i < got.size()) ? got[i] : 16'hxxxx;
         checks++;
         if (act !== 16'h112C + 16'(i)) begin
            failures++;
            $display("FAIL starve_beat%0d got=%h exp=%h", i, act, 16'h112C + 16'(i));
         end
      end

      clear_mon();
      start_pass(10'd500, 11'd1, 1'b0);
      wait_done(20);
      act = (got.size() > 0) ? got[0] : 16'hxxxx;
      checks++;
      if (act !== 16'hBEEF || got.size() != 1) begin
         failures++;
         $display("FAIL readback got=%h/n%0d exp=beef/n1", act, got.size());
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] act;
      clear_mon();
      st_if.ready = 1'b0;
      start_pass(10'd0, 11'd16, 1'b0);
      while (cyc < 5) tick();
      checks++;
      if (dut.fifo_count !== 3'd3) begin
         failures++;
         $display("FAIL arst_pre_fill got=%0d exp=3", dut.fifo_count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (st_if.valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL arst_async got=valid%b/busy%b exp=valid0/busy0", st_if.valid, busy);
      end
      repeat (2) @(posedge clk_hifreq);
      #1;
      rst_n = 1'b1;
      clear_mon();
      st_if.ready = 1'b1;
      repeat (5) tick();
      checks++;
      if (got.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL arst_after got=beats%0d/done%0d/busy%b exp=beats0/done0/busy0", got.size(), done_cnt, busy);
      end
      clear_mon();
      start_pass(10'd7, 11'd2, 1'b0);
      wait_done(20);
      for (int i = 0; i < 2; i++) begin
         act = (i < got.size()) ? got[i] : 16'hxxxx;
         checks++;
         if (act !== 16'h1007 + 16'(i)) begin
            failures++;
            $display("FAIL arst_rerun%0d got=%h exp=%h", i, act, 16'h1007 + 16'(i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_loop_stop();
      test_write_contention();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/ram_playback_ctrl.md
Name: ram_playback_ctrl

Overview:
- Sequences reads from the single-port test RAM (1024 x 32, registered address, 1-cycle read latency) and streams words onto an Avalon-ST source, never losing data under backpressure.
- Shares the same RAM port with a host write port.
- Sits between the host/config logic, the RAM instance and the downstream consumer of the 16-bit stream.

Parameters:
- ADDR_W, 10, RAM address width (RAM depth = 2**ADDR_W).
- FIFO_DEPTH, 4, output buffer entries (power of 2, >= RD_LAT+2).
- RD_LAT, 1, RAM read latency in cycles.
- STARVE_MAX, 8, maximum cycles a pending host write may wait during RUN.

Ports:
- clk_hifreq  in  1  sole clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle start request; sampled in IDLE only.
- stop  in  1  one-cycle stop request; sampled in RUN only.
- cfg_base  in  ADDR_W  first word address; latched on an accepted start.
- cfg_len  in  ADDR_W+1  words per pass, 1..1024; 0 means the start is ignored.
- cfg_loop  in  1  repeat the pass until stop; latched on an accepted start.
- wr_req  in  1  host write request; held until wr_ack.
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  32  host write data.
- wr_ack  out  1  one-cycle pulse: the write was issued to the RAM this cycle.
- ram_address  out  ADDR_W  RAM address.
- ram_data  out  32  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  32  RAM read data.
- data_out  out  16  stream data.
- valid  out  1  stream valid.
- ready  in  1  stream ready; ready latency 0.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset values: every output 0, FSM in IDLE, FIFO empty, in-flight pipe cleared.
- Reset asserted mid-operation:
  - aborts immediately and drops valid asynchronously;
  - in-flight reads and FIFO contents are discarded;
  - no done pulse.
- FSM states and transitions:
  - IDLE to RUN: on start with cfg_len != 0. Latch base/len/loop; word offset = 0.
  - RUN to DRAIN: after the last word of a pass is issued with loop = 0, or when stop is asserted.
  - RUN looping: when loop = 1, wrap the offset to 0 after the last word of each pass.
  - DRAIN to IDLE: once the in-flight pipe and FIFO are both empty. Pulse done for one cycle.
  - Ignored inputs: start outside IDLE and stop outside RUN.
- Read issue:
  - Read address = (base + offset) mod 2**ADDR_W, so addresses wrap 1023 to 0.
  - A read is issued only if fifo_count + in_flight < FIFO_DEPTH (credit). This guarantees every returned word has a FIFO slot.
  - ram_q is captured into the FIFO exactly RD_LAT cycles after issue, tracked by a valid shift register.
- Stream:
  - valid = FIFO not empty; data_out = FIFO head.
  - A beat transfers when valid and ready are both high.
  - While valid is high and ready is low, data_out is held stable.
  - Full throughput of 1 word/cycle when ready stays high.
  - A FIFO push and pop in the same cycle leaves the count unchanged. Pushing while full is impossible by the credit rule; verification asserts it never happens.
- Arbitration (single RAM port):
  - IDLE/DRAIN: a pending write is granted immediately (ram_wren = 1, wr_ack = 1).
  - RUN: a write is granted on any cycle with no read issued (credit exhausted).
  - RUN starvation: a wait counter forces a grant after STARVE_MAX consecutive pending cycles, and the read is skipped that cycle.
  - The wait counter clears on grant.
  - At most one RAM access per cycle. ram_data = wr_data, driven only on write cycles; 0 otherwise.
- stop arriving on the same cycle the last word issues: a single transition to DRAIN.

Optional Feature:
- Macro PLAYBACK_SPLIT_EN.
- Defined: each RAM word emits two beats, ram_q[15:0] then ram_q[31:16]. The high half is presented only after the low beat transfers. FIFO occupancy counts words.
- Undefined: one beat per word, ram_q[15:0]; the upper half is discarded.

Decomposition:
- Package playback_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - constants ADDR_W = 10, WORD_W = 32, BEAT_W = 16;
  - the RAM depth localparam.
- One sub-module, playback_fifo: synchronous FIFO with push, pop, count, full and empty, async active-low reset, no lookahead logic beyond the head register.

Test Plan:
- Basic pass: RAM preloaded with word i = 32'h0000_1000+i; start, base = 5, len = 4, ready = 1 -> beats 1005, 1006, 1007, 1008 on consecutive cycles; done 1 cycle after the last beat; busy low after.
- Address wrap: base = 1022, len = 4 -> addresses 1022, 1023, 0, 1 read in order.
- Backpressure: ready toggling 1,0,0,1 random over len = 16 -> all 16 beats in order, none duplicated or lost; data_out stable while stalled; FIFO never overflows.
- Loop plus stop: loop = 1, len = 3 -> pattern repeats A,B,C,A,B,C; stop mid-pass -> issue halts, in-flight words drain, done pulses once.
- Write contention: RUN with ready = 1 and wr_req held -> wr_ack within STARVE_MAX+1 cycles; a subsequent pass reads the new data.
- Async reset: assert rst_n = 0 mid-RUN with FIFO holding 3 words -> valid drops immediately; after release, IDLE with an empty FIFO and no done pulse.
